// File: rtl/frame_scheduler.sv
// frame_scheduler: walks an utterance held in sample memory as overlapping
// frames (FRAME_LEN samples, starting every HOP samples). A frame is issued
// only after the upstream writer has filled all of its samples. Addresses
// leave one per cycle under a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   start       begin one schedule (sampled only while idle)
//   wr_cnt      samples already written to sample memory
//   rd_ready    downstream accepts the current address
//   rd_en       rd_addr valid
//   rd_addr     sample memory read address
//   frame_idx   index of the frame being issued
//   frame_first rd_en on offset 0 of a frame
//   frame_last  rd_en on offset FRAME_LEN-1 of a frame
//   busy        schedule in progress (any state but IDLE)
//   done        one-cycle pulse after the last frame's final address
module frame_scheduler #(
  parameter  int TOTAL_DATA = 15104,
  parameter  int FRAME_LEN  = 512,
  parameter  int HOP        = 128,
  localparam int NUM_FRAMES = (TOTAL_DATA - FRAME_LEN) / HOP + 1,
  localparam int AW         = $clog2(TOTAL_DATA),
  localparam int CW         = $clog2(TOTAL_DATA + 1),
  localparam int FW         = $clog2(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] wr_cnt,
  input  logic          rd_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [FW-1:0] frame_idx,
  output logic          frame_first,
  output logic          frame_last,
  output logic          busy,
  output logic          done
);

  localparam int              OW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [OW-1:0]   OFF_LAST = OW'(FRAME_LEN - 1);
  localparam logic [FW-1:0]   FRM_LAST = FW'(NUM_FRAMES - 1);
  localparam logic [AW-1:0]   HOP_A    = AW'(HOP);
  localparam logic [CW:0]     LEN_C    = (CW+1)'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] base_q;
  logic [OW-1:0] offset_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic [FW-1:0] frame_idx_q;
  logic          frame_first_q;
  logic          frame_last_q;
  logic          busy_q;
  logic          done_q;

  // One extra bit so base+FRAME_LEN can never wrap in the fill compare.
  logic [CW:0] need_d;
  logic        fill_ok_d;
  assign need_d    = (CW+1)'(base_q) + LEN_C;
  assign fill_ok_d = {1'b0, wr_cnt} >= need_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      offset_q      <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      frame_idx_q   <= '0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= WAIT;
            busy_q      <= 1'b1;
            base_q      <= '0;
            offset_q    <= '0;
            frame_idx_q <= '0;
          end
        end
        WAIT: begin
          // wr_cnt is only looked at here; once a frame is issuing, the
          // writer going backwards cannot disturb it.
          if (fill_ok_d) begin
            state_q       <= ISSUE;
            rd_en_q       <= 1'b1;
            rd_addr_q     <= base_q;
            frame_first_q <= 1'b1;
            frame_last_q  <= (OFF_LAST == '0);
          end
        end
        ISSUE: begin
          if (rd_ready) begin
            frame_first_q <= 1'b0;
            if (offset_q != OFF_LAST) begin
              // rd_addr tracks base+offset incrementally
              offset_q     <= offset_q + 1'b1;
              rd_addr_q    <= rd_addr_q + 1'b1;
              frame_last_q <= (offset_q == OFF_LAST - 1'b1);
            end else begin
              rd_en_q      <= 1'b0;
              frame_last_q <= 1'b0;
              offset_q     <= '0;
              if (frame_idx_q != FRM_LAST) begin
                // back through WAIT guarantees an idle cycle between frames
                base_q      <= base_q + HOP_A;
                frame_idx_q <= frame_idx_q + 1'b1;
                state_q     <= WAIT;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign frame_idx   = frame_idx_q;
  assign frame_first = frame_first_q;
  assign frame_last  = frame_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler. A tiny instance (10/4/2) is driven from a
// cycle-by-cycle vector table; a mid-size instance (600/64/16) runs full,
// ramped, random and reset-interrupted schedules against a frame/offset
// reference model evaluated every cycle.
module tb_frame_scheduler;

  // small instance
  localparam int ST = 10, SF = 4, SH = 2;
  localparam int SNF = (ST - SF) / SH + 1;
  localparam int SAW = $clog2(ST), SCW = $clog2(ST + 1), SFW = $clog2(SNF);
  // main instance
  localparam int MT = 600, MF = 64, MH = 16;
  localparam int MNF = (MT - MF) / MH + 1;
  localparam int MAW = $clog2(MT), MCW = $clog2(MT + 1), MFW = $clog2(MNF);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           s_rst, s_start, s_rdy;
  logic [SCW-1:0] s_wr;
  logic           s_en, s_first, s_last, s_busy, s_done;
  logic [SAW-1:0] s_addr;
  logic [SFW-1:0] s_idx;

  logic           m_rst, m_start, m_rdy;
  logic [MCW-1:0] m_wr;
  logic           m_en, m_first, m_last, m_busy, m_done;
  logic [MAW-1:0] m_addr;
  logic [MFW-1:0] m_idx;

  frame_scheduler #(.TOTAL_DATA(ST), .FRAME_LEN(SF), .HOP(SH)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .wr_cnt(s_wr), .rd_ready(s_rdy),
    .rd_en(s_en), .rd_addr(s_addr), .frame_idx(s_idx), .frame_first(s_first),
    .frame_last(s_last), .busy(s_busy), .done(s_done));

  frame_scheduler #(.TOTAL_DATA(MT), .FRAME_LEN(MF), .HOP(MH)) u_main (
    .clk(clk), .rst(m_rst), .start(m_start), .wr_cnt(m_wr), .rd_ready(m_rdy),
    .rd_en(m_en), .rd_addr(m_addr), .frame_idx(m_idx), .frame_first(m_first),
    .frame_last(m_last), .busy(m_busy), .done(m_done));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model for the main instance ----------------
  // ph: 0 idle, 1 scheduling, 2 done cycle. fr/off: next address to issue.
  bit mon_on = 0;
  int ph = 0, fr = 0, off = 0;
  bit e_zero = 1, e_busy = 0, e_done = 0, e_en = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("m_busy", m_busy, e_busy);
      chk("m_done", m_done, e_done);
      chk("m_rd_en", m_en, e_en);
      if (e_zero) begin
        chk("m_rst_addr", m_addr, 0);
        chk("m_rst_idx", m_idx, 0);
        chk("m_rst_first", m_first, 0);
        chk("m_rst_last", m_last, 0);
      end else if (e_en) begin
        chk("m_addr", m_addr, fr * MH + off);
        chk("m_addr_range", m_addr <= MT - 1, 1);
        chk("m_idx", m_idx, fr);
        chk("m_first", m_first, off == 0);
        chk("m_last", m_last, off == MF - 1);
      end else begin
        chk("m_first_noen", m_first, 0);
        chk("m_last_noen", m_last, 0);
      end
      if (m_done === 1'b1) done_cnt++;
      // expectations for the next sample
      if (!m_rst) begin
        ph = 0; e_zero = 1; e_busy = 0; e_done = 0; e_en = 0;
      end else begin
        e_zero = 0;
        e_done = 0;
        case (ph)
          0: begin
            e_en = 0;
            if (m_start) begin ph = 1; fr = 0; off = 0; e_busy = 1; end
            else e_busy = 0;
          end
          1: begin
            e_busy = 1;
            if (e_en) begin
              if (m_rdy) begin
                if (off == MF - 1) begin
                  e_en = 0;
                  off  = 0;
                  if (fr == MNF - 1) begin ph = 2; e_done = 1; end
                  else fr++;
                end else off++;
              end
            end else e_en = (int'(m_wr) >= fr * MH + MF);
          end
          default: begin ph = 0; e_busy = 0; e_en = 0; end
        endcase
      end
    end
  end

  // ---------------- vector table for the small instance ----------------
  typedef struct {
    bit st; bit rdy; int wr;
    bit en; int addr; int idx; bit f; bit l; bit busy; bit done;
  } vec_t;
  vec_t tv[30];

  initial begin
    int d0, hs, n;
    bit seen0, seen1;

    //          st rdy wr   en addr idx f  l  busy done
    tv[0]  = '{0, 0, 0,    0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 3,    0, 0, 0, 0, 0, 1, 0};
    tv[2]  = '{0, 0, 3,    0, 0, 0, 0, 0, 1, 0};
    tv[3]  = '{0, 0, 4,    1, 0, 0, 1, 0, 1, 0};
    tv[4]  = '{0, 0, 4,    1, 0, 0, 1, 0, 1, 0};
    tv[5]  = '{1, 1, 4,    1, 1, 0, 0, 0, 1, 0};
    tv[6]  = '{0, 1, 4,    1, 2, 0, 0, 0, 1, 0};
    tv[7]  = '{0, 0, 4,    1, 2, 0, 0, 0, 1, 0};
    tv[8]  = '{0, 1, 4,    1, 3, 0, 0, 1, 1, 0};
    tv[9]  = '{0, 1, 4,    0, 0, 1, 0, 0, 1, 0};
    tv[10] = '{0, 1, 5,    0, 0, 1, 0, 0, 1, 0};
    tv[11] = '{0, 1, 6,    1, 2, 1, 1, 0, 1, 0};
    tv[12] = '{0, 1, 2,    1, 3, 1, 0, 0, 1, 0};
    tv[13] = '{0, 1, 2,    1, 4, 1, 0, 0, 1, 0};
    tv[14] = '{0, 1, 2,    1, 5, 1, 0, 1, 1, 0};
    tv[15] = '{0, 1, 10,   0, 0, 2, 0, 0, 1, 0};
    tv[16] = '{0, 1, 10,   1, 4, 2, 1, 0, 1, 0};
    tv[17] = '{0, 1, 10,   1, 5, 2, 0, 0, 1, 0};
    tv[18] = '{0, 1, 10,   1, 6, 2, 0, 0, 1, 0};
    tv[19] = '{0, 1, 10,   1, 7, 2, 0, 1, 1, 0};
    tv[20] = '{0, 1, 10,   0, 0, 3, 0, 0, 1, 0};
    tv[21] = '{0, 1, 10,   1, 6, 3, 1, 0, 1, 0};
    tv[22] = '{0, 1, 10,   1, 7, 3, 0, 0, 1, 0};
    tv[23] = '{0, 1, 10,   1, 8, 3, 0, 0, 1, 0};
    tv[24] = '{0, 1, 10,   1, 9, 3, 0, 1, 1, 0};
    tv[25] = '{1, 1, 10,   0, 0, 3, 0, 0, 1, 1};
    tv[26] = '{1, 0, 10,   0, 0, 0, 0, 0, 0, 0};
    tv[27] = '{0, 0, 10,   0, 0, 0, 0, 0, 0, 0};
    tv[28] = '{1, 1, 10,   0, 0, 0, 0, 0, 1, 0};
    tv[29] = '{0, 1, 10,   1, 0, 0, 1, 0, 1, 0};

    s_rst = 0; s_start = 0; s_rdy = 0; s_wr = '0;
    m_rst = 0; m_start = 0; m_rdy = 0; m_wr = '0;
    cyc(); cyc();
    mon_on = 1;

    // reset state
    chk("s_rst_en", s_en, 0);     chk("s_rst_busy", s_busy, 0);
    chk("s_rst_done", s_done, 0); chk("s_rst_addr", s_addr, 0);
    chk("s_rst_idx", s_idx, 0);   chk("s_rst_fl", {s_first, s_last}, 0);

    s_rst = 1;
    for (int i = 0; i < 30; i++) begin
      s_start = tv[i].st; s_rdy = tv[i].rdy; s_wr = SCW'(tv[i].wr);
      cyc();
      chk($sformatf("v%0d_en", i), s_en, tv[i].en);
      chk($sformatf("v%0d_busy", i), s_busy, tv[i].busy);
      chk($sformatf("v%0d_done", i), s_done, tv[i].done);
      chk($sformatf("v%0d_first", i), s_first, tv[i].f);
      chk($sformatf("v%0d_last", i), s_last, tv[i].l);
      if (tv[i].en) chk($sformatf("v%0d_addr", i), s_addr, tv[i].addr);
      if (tv[i].busy) chk($sformatf("v%0d_idx", i), s_idx, tv[i].idx);
    end
    // reset mid-frame on the small instance
    s_rst = 0; s_start = 0;
    cyc();
    chk("s_midrst_en", s_en, 0);   chk("s_midrst_busy", s_busy, 0);
    chk("s_midrst_addr", s_addr, 0); chk("s_midrst_first", s_first, 0);
    s_rst = 1;

    // ---- A: data all present, always ready ----
    m_rst = 1; m_wr = MCW'(MT); m_rdy = 1;
    d0 = done_cnt; hs = 0; n = 0;
    m_start = 1; cyc(); m_start = 0;
    while (m_done !== 1'b1 && n < 5000) begin
      if (m_en && m_rdy) hs++;
      cyc(); n++;
    end
    chk("A_done_seen", m_done, 1);
    chk("A_busy_in_done", m_busy, 1);
    chk("A_handshakes", hs, MNF * MF);
    cyc();
    chk("A_busy_after_done", m_busy, 0);
    chk("A_done_once", done_cnt - d0, 1);

    // ---- B: writer ramps one sample every 4 cycles ----
    m_wr = '0; m_rdy = 1; d0 = done_cnt; n = 0; seen0 = 0; seen1 = 0;
    m_start = 1; cyc(); m_start = 0;
    while (m_done !== 1'b1 && n < 4000) begin
      cyc(); n++;
      if (m_en && m_first && m_idx == 0 && !seen0) begin
        seen0 = 1; chk("B_f0_wr", m_wr, MF);
      end
      if (m_en && m_first && m_idx == 1 && !seen1) begin
        seen1 = 1; chk("B_f1_wr_ge", int'(m_wr) >= MF + MH, 1);
      end
      if (n % 4 == 0 && int'(m_wr) < MT) m_wr = m_wr + 1'b1;
    end
    chk("B_done_seen", m_done, 1);
    chk("B_seen_frames", {seen0, seen1}, 2'b11);
    cyc();
    chk("B_done_once", done_cnt - d0, 1);

    // ---- C: random ready, random writer, stray starts ----
    m_wr = '0; d0 = done_cnt; n = 0;
    m_rdy = 1'($urandom_range(0, 1));
    m_start = 1; cyc();
    while (m_done !== 1'b1 && n < 20000) begin
      m_start = ($urandom_range(0, 7) == 0);
      m_rdy   = 1'($urandom_range(0, 1));
      if (int'(m_wr) < MT) m_wr = m_wr + MCW'($urandom_range(0, 1));
      cyc(); n++;
    end
    chk("C_done_seen", m_done, 1);
    m_start = 1; cyc();            // start during the done cycle
    chk("C_busy_after_done", m_busy, 0);
    m_start = 0; cyc(); cyc(); cyc();
    chk("C_no_restart", m_busy, 0);
    chk("C_done_once", done_cnt - d0, 1);

    // ---- D: reset during frame 3, offset 20 ----
    m_wr = MCW'(MT); m_rdy = 1; n = 0;
    m_start = 1; cyc(); m_start = 0;
    while (!(m_en && m_idx == 3 && int'(m_addr) == 3 * MH + 20) && n < 1000) begin
      cyc(); n++;
    end
    chk("D_reached", m_en && int'(m_addr) == 3 * MH + 20, 1);
    m_rst = 0; cyc();
    chk("D_en", m_en, 0);     chk("D_busy", m_busy, 0);
    chk("D_addr", m_addr, 0); chk("D_idx", m_idx, 0);
    chk("D_fl", {m_first, m_last}, 0); chk("D_done", m_done, 0);
    m_rst = 1; m_start = 1; cyc(); m_start = 0;
    n = 0;
    while (m_en !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("D_restart_addr", m_addr, 0);
    chk("D_restart_idx", m_idx, 0);
    chk("D_restart_first", m_first, 1);
    m_rst = 0; cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
